// File: rtl/shf_seq.sv
// -----------------------------------------------------------------------------
// shf_seq -- multi-cycle sequential shifter with tri-state result bus
//
// The operand is captured on start. It is then shifted by up to STEP bit
// positions per clock until the requested amount has been applied. The
// result is latched into a result register and driven onto dout while oe=1.
//
// Parameters
//   WIDTH  data width (power of two, >= 8)
//   STEP   bit positions shifted per cycle (1, 2 or 4)
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   start  request an operation (sampled in IDLE only)
//   mode   00 LSHF, 01 RSHFL, 10 ROTL, 11 RSHFA
//   amt    shift amount, 0 .. WIDTH-1
//   din    operand
//   oe     output enable for dout
//   dout   result register while oe=1, high-Z otherwise
//   busy   high while the state is BUSY
//   done   one-cycle pulse while the state is DONE
//   err    set on completion of an unsupported mode, cleared otherwise
//
// Configuration macro
//   SHF_SEQ_ROTATE_EN  when defined, mode 10 rotates left. When undefined,
//                      the rotate datapath is left out. Mode 10 then still
//                      completes with normal timing, returns 0 and sets err.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// BUSY  | shifting the working register, remaining > 0 means more steps
// DONE  | result register just updated, done pulse for one cycle
// -----------------------------------------------------------------------------
module shf_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [WIDTH-1:0]         din,
  input  logic                     oe,
  output logic [WIDTH-1:0]         dout,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
`ifdef SHF_SEQ_ROTATE_EN
  localparam logic [CW:0] WIDTH_C = (CW+1)'(WIDTH);
`endif

  localparam logic [1:0] M_LSHF  = 2'b00;
  localparam logic [1:0] M_RSHFL = 2'b01;
  localparam logic [1:0] M_ROTL  = 2'b10;
  localparam logic [1:0] M_RSHFA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] result;
  logic [1:0]       mode_r;
  logic [CW-1:0]    remaining;

  logic [CW-1:0]    k;
  logic [WIDTH-1:0] shifted;
  logic             supported;

  // One step of the shift. k is min(STEP, remaining). For RSHFA, the
  // working register's MSB is still the captured sign bit after every
  // arithmetic step, so each step can use >>> on the current value.
  always_comb begin
    k       = (remaining < STEP_C) ? remaining : STEP_C;
    shifted = work;
    case (mode_r)
      M_LSHF:  shifted = work << k;
      M_RSHFL: shifted = work >> k;
      M_RSHFA: shifted = WIDTH'($signed(work) >>> k);
`ifdef SHF_SEQ_ROTATE_EN
      M_ROTL:  shifted = (work << k) | (work >> (WIDTH_C - {1'b0, k}));
`endif
      default: shifted = work;
    endcase
  end

  always_comb begin
`ifdef SHF_SEQ_ROTATE_EN
    supported = 1'b1;
`else
    supported = (mode_r != M_ROTL);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      work      <= '0;
      mode_r    <= M_LSHF;
      remaining <= '0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work      <= din;
            mode_r    <= mode;
            remaining <= amt;
            state     <= BUSY;
            busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (remaining != '0) begin
            work      <= shifted;
            remaining <= remaining - k;
          end else begin
            result <= supported ? work : '0;
            err    <= ~supported;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = oe ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_shf_seq.sv
module tb_shf_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  amt = 4'd0;
  logic [15:0] din = 16'h0000;
  logic        oe = 1'b1;

  wire  [15:0] dout1, dout4;
  logic        busy1, done1, err1;
  logic        busy4, done4, err4;

  int tests = 0;
  int fails = 0;
  logic [15:0] last_res = 16'h0000;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  shf_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .din(din),
    .oe(oe), .dout(dout1), .busy(busy1), .done(done1), .err(err1)
  );

  shf_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .din(din),
    .oe(oe), .dout(dout4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Whole-operation reference: the full shift applied at once.
  task automatic model(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                       output logic [15:0] res, output logic e);
    logic [31:0] wide;
    e = 1'b0;
    case (m)
      2'b00: res = d << a;
      2'b01: res = d >> a;
      2'b11: begin
        wide = {{16{d[15]}}, d} >> a;
        res  = wide[15:0];
      end
      default: begin
`ifdef SHF_SEQ_ROTATE_EN
        wide = {d, d} << a;
        res  = wide[31:16];
`else
        res = 16'h0000;
        e   = 1'b1;
`endif
      end
    endcase
  endtask

  // Launch one operation on both instances and watch them complete.
  task automatic run_op(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                        input bit poke);
    int lat1 = 1 + int'(a);
    int lat4 = 1 + (int'(a) + 3) / 4;
    int done_at1 = -1, done_at4 = -1;
    int busy_n1 = 0, busy_n4 = 0, done_n1 = 0, done_n4 = 0;
    logic [15:0] exp;
    logic        exp_err;
    model(d, m, a, exp, exp_err);
    din = d; mode = m; amt = a; start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < lat1 + 4; c++) begin
      @(negedge clk);
      if (busy1) busy_n1++;
      if (busy4) busy_n4++;
      if (done1) begin done_n1++; if (done_at1 < 0) done_at1 = c; end
      if (done4) begin done_n4++; if (done_at4 < 0) done_at4 = c; end
      if (c == 0) begin
        check("dout1_hold", 32'(dout1), 32'(last_res));
        start = 1'b0;
        din = 16'($urandom); mode = 2'($urandom); amt = 4'($urandom);
      end
      if (c == 1 && poke) begin
        start = 1'b1; din = 16'h1234;
      end
      if (c == 2) start = 1'b0;
    end
    check("done_at1", 32'(done_at1), 32'(lat1));
    check("done_at4", 32'(done_at4), 32'(lat4));
    check("done_width1", 32'(done_n1), 32'd1);
    check("done_width4", 32'(done_n4), 32'd1);
    check("busy_cycles1", 32'(busy_n1), 32'(lat1));
    check("busy_cycles4", 32'(busy_n4), 32'(lat4));
    check("result1", 32'(dout1), 32'(exp));
    check("result4", 32'(dout4), 32'(exp));
    check("err1", 32'(err1), 32'(exp_err));
    check("err4", 32'(err4), 32'(exp_err));
    last_res = exp;
    last_err = exp_err;
  endtask

  task automatic reset_mid_busy();
    int seen = 0;
    din = 16'h8001; mode = 2'b00; amt = 4'd12; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst1", 32'(busy1), 32'd1);
    check("busy_before_rst4", 32'(busy4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done1 || done4) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_busy1", 32'(busy1), 32'd0);
    check("abort_dout1", 32'(dout1), 32'd0);
    check("abort_dout4", 32'(dout4), 32'd0);
    check("abort_err1", 32'(err1), 32'd0);
    last_res = 16'h0000;
    last_err = 1'b0;
  endtask

  initial begin
    logic [15:0] zz;
    zz = 16'hzzzz;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_dout1", 32'(dout1), 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_dout4", 32'(dout4), 32'd0);
    check("rst_err4", 32'(err4), 32'd0);

    run_op(16'h8001, 2'b00, 4'd4, 1'b0);
    run_op(16'h8000, 2'b11, 4'd15, 1'b0);
    run_op(16'h8000, 2'b01, 4'd15, 1'b0);
    run_op(16'h8001, 2'b10, 4'd1, 1'b0);
    run_op(16'hFFFF, 2'b00, 4'd15, 1'b0);
    run_op(16'hABCD, 2'b00, 4'd0, 1'b0);
    run_op(16'hF0F0, 2'b11, 4'd9, 1'b1);
    run_op(16'h0F0F, 2'b10, 4'd7, 1'b1);

    reset_mid_busy();
    run_op(16'h8001, 2'b00, 4'd4, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));

    oe = 1'b0;
    @(negedge clk);
    check("oe0_dout1", 32'(dout1), 32'(zz));
    check("oe0_dout4", 32'(dout4), 32'(zz));
    oe = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_stable1", 32'(dout1), 32'(last_res));
      check("idle_stable4", 32'(dout4), 32'(last_res));
    end
    check("idle_err1", 32'(err1), 32'(last_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shf_seq.md
SHF_SEQ -- requirements
Module: shf_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width in bits; legal values are powers of two, 8 or more.
REQ-002 The block SHALL have parameter STEP, default 1: bit positions shifted per cycle; legal values are 1, 2 or 4.
REQ-003 The block SHALL derive localparam CW = clog2(WIDTH), the shift-amount width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request a shift operation.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 LSHF, 01 RSHFL, 10 ROTL, 11 RSHFA.
REQ-008 The block SHALL have port amt, input, CW bits: shift amount, 0 to WIDTH-1.
REQ-009 The block SHALL have port din, input, WIDTH bits: operand.
REQ-010 The block SHALL have port oe, input, 1 bit: output enable for the bus driver.
REQ-011 The block SHALL have port dout, output, WIDTH bits: the result register while oe=1; all bits high-Z while oe=0.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-014 The block SHALL have port err, output, 1 bit: set when an unsupported mode is requested.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture din, mode and amt into working registers, load remaining=amt, and enter BUSY.
REQ-017 start SHALL be ignored in BUSY and DONE; operand changes after capture SHALL not affect the operation.
REQ-018 Each BUSY edge with remaining>0 SHALL shift the working register by k=min(STEP, remaining) and set remaining -= k.
REQ-019 A BUSY edge with remaining=0 SHALL copy the working register to the result register, clear err for a supported mode, and enter DONE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 With start sampled at edge N, done SHALL be high during the cycle following edge N+1+ceil(amt/STEP); amt=0 therefore gives done after edge N+1.
REQ-022 busy SHALL be 1 exactly when the state is BUSY; done SHALL be 1 exactly when the state is DONE.
REQ-023 LSHF and RSHFL SHALL zero-fill vacated bits.
REQ-024 RSHFA SHALL fill vacated bits with bit WIDTH-1 of the captured din.
REQ-025 ROTL SHALL rotate left, with bits leaving the MSB re-entering at the LSB.
REQ-026 The result register SHALL change only on entry to DONE and SHALL hold until the next completion; dout SHALL be combinational from oe and the result register.
REQ-027 err SHALL update only on entry to DONE and SHALL otherwise hold.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE and clear the result register, working register, remaining count and err, taking priority over start and any in-progress operation.
REQ-029 After reset, busy and done SHALL be 0 and dout SHALL be 0 while oe=1.
REQ-030 An operation aborted by reset SHALL NOT assert done and SHALL NOT update the result register.

Configuration
REQ-031 With macro SHF_SEQ_ROTATE_EN defined, mode 10 SHALL perform ROTL per REQ-025 and leave err=0.
REQ-032 Without SHF_SEQ_ROTATE_EN, mode 10 SHALL still complete with the normal REQ-021 timing, produce result 0, and set err=1.
REQ-033 Without SHF_SEQ_ROTATE_EN, the rotate datapath SHALL be absent; all other modes SHALL be unchanged.

Verification (WIDTH=16 unless stated)
REQ-034 STEP=1, din=16'h8001, mode=00, amt=4, start at edge N -> dout=16'h0010, done during the cycle after edge N+5, busy high for 5 cycles.
REQ-035 STEP=1, din=16'h8000, mode=11, amt=15 -> 16'hFFFF; the same with mode=01 -> 16'h0001.
REQ-036 din=16'h8001, mode=10, amt=1 -> 16'h0003, err=0 with SHF_SEQ_ROTATE_EN; 16'h0000, err=1 without it.
REQ-037 STEP=4, din=16'hFFFF, mode=00, amt=15 -> 16'h8000, done after edge N+5; amt=0 -> din unchanged, done after edge N+1.
REQ-038 start pulsed with din=16'h1234 while busy -> ignored; the first result completes intact. rst asserted mid-BUSY -> no done, dout=0, next start works normally.
REQ-039 oe=0 -> dout all Z; oe=1 -> last result, stable across idle cycles.
